// File: rtl/debug_trace_pkg.sv
// debug_trace_pkg: state encoding, entry sizing and entry layout for the trace buffer.
// Build option TRACE_TSTAMP_EN appends a per-sample timestamp field.
package debug_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_POST = 2'd2,
      ST_DONE = 2'd3
   } trace_state_e;

   localparam int PC_W_DEF   = 32;
   localparam int INST_W_DEF = 32;
   localparam int ALU_W_DEF  = 16;
   localparam int TS_W_DEF   = 16;

`ifdef TRACE_TSTAMP_EN
   localparam bit TSTAMP_EN = 1'b1;
`else
   localparam bit TSTAMP_EN = 1'b0;
`endif

   // Stored bits per sample; the timestamp only costs bits when enabled.
   function automatic int entry_w(input int pc_w, input int inst_w,
                                  input int alu_w, input int ts_w,
                                  input bit ts_en);
      return pc_w + inst_w + alu_w + (ts_en ? ts_w : 0);
   endfunction

   // Entry layout at default widths, MSB first: {pc, inst, alu[, tstamp]}.
   typedef struct packed {
      logic [PC_W_DEF-1:0]   pc;
      logic [INST_W_DEF-1:0] inst;
      logic [ALU_W_DEF-1:0]  alu;
`ifdef TRACE_TSTAMP_EN
      logic [TS_W_DEF-1:0]   tstamp;
`endif
   } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port DEPTH x WIDTH storage for captured samples.
// Synchronous write, registered read, contents never reset.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 80,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Capture a sample into the addressed slot.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read port registered every cycle; readout holds by re-reading.
   always_ff @(posedge clk_i) begin
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: triggered circular capture of core debug samples with
// oldest-first valid/ready playback. TRACE_TSTAMP_EN adds timestamps.
module debug_trace_buffer
   import debug_trace_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int INST_W    = 32,
   parameter int ALU_W     = 16,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4,
   parameter int TS_W      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [PC_W-1:0]        debug_pc,
   input  logic [INST_W-1:0]      debug_inst,
   input  logic [ALU_W-1:0]       debug_alu_out,
   input  logic                   arm,
   input  logic                   abort,
   input  logic                   trig_en,
   input  logic [PC_W-1:0]        trig_pc,
   input  logic                   force_trig,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [PC_W-1:0]        rd_pc,
   output logic [INST_W-1:0]      rd_inst,
   output logic [ALU_W-1:0]       rd_alu,
`ifdef TRACE_TSTAMP_EN
   output logic [TS_W-1:0]        rd_tstamp,
`endif
   output logic [1:0]             state,
   output logic [$clog2(DEPTH):0] entries,
   output logic                   triggered
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int EW    = entry_w(PC_W, INST_W, ALU_W, TS_W, TSTAMP_EN);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_TRIG);

   trace_state_e     state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] entries_q, entries_d;
   logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
   logic [CNT_W-1:0] rd_left_q, rd_left_d;
   logic             trig_q, trig_d;
   logic             rd_valid_q, rd_valid_d;

   logic             trig_hit;
   logic             do_wr;
   logic             do_arm;
   logic             xfer;
   logic [EW-1:0]    wdata;
   logic [EW-1:0]    rdata;

   assign trig_hit = (trig_en && in_valid && (debug_pc == trig_pc))
                     || force_trig;
   assign do_wr    = !abort && in_valid
                     && (state_q == ST_PRE || state_q == ST_POST);
   assign do_arm   = !abort && arm
                     && (state_q == ST_IDLE || state_q == ST_DONE);
   assign xfer     = rd_valid_q && rd_ready;

`ifdef TRACE_TSTAMP_EN
   logic [TS_W-1:0] ts_q;

   // Free-running sample clock stamp.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   assign wdata     = {debug_pc, debug_inst, debug_alu_out, ts_q};
   assign rd_tstamp = rd_valid_q ? rdata[TS_W-1:0] : '0;
`else
   assign wdata = {debug_pc, debug_inst, debug_alu_out};
`endif

   // Capture window, trigger countdown and playback sequencing.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      entries_d  = entries_q;
      post_cnt_d = post_cnt_q;
      rd_left_d  = rd_left_q;
      trig_d     = trig_q;
      rd_valid_d = 1'b0;

      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (entries_q != DEPTH_C) begin
            entries_d = entries_q + CNT_W'(1);
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (do_arm) begin
               state_d    = ST_PRE;
               wr_ptr_d   = '0;
               entries_d  = '0;
               post_cnt_d = '0;
               trig_d     = 1'b0;
            end
         end
         ST_PRE: begin
            if (trig_hit) begin
               trig_d     = 1'b1;
               post_cnt_d = '0;
               state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
            end
         end
         ST_POST: begin
            if (do_wr) begin
               post_cnt_d = post_cnt_q + CNT_W'(1);
               if (post_cnt_d == POST_C) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (do_arm) begin
               state_d    = ST_PRE;
               wr_ptr_d   = '0;
               entries_d  = '0;
               post_cnt_d = '0;
               trig_d     = 1'b0;
            end else if (xfer) begin
               rd_ptr_d  = rd_ptr_q + AW'(1);
               rd_left_d = rd_left_q - CNT_W'(1);
            end
         end
      endcase

      // Oldest entry is at wr_ptr once the ring has wrapped, else slot 0.
      if (state_d == ST_DONE && state_q != ST_DONE) begin
         rd_ptr_d  = (entries_d == DEPTH_C) ? wr_ptr_d : '0;
         rd_left_d = entries_d;
      end

      if (state_q == ST_DONE && state_d == ST_DONE) begin
         rd_valid_d = (rd_left_d != '0);
      end

      if (abort) begin
         state_d    = ST_IDLE;
         entries_d  = '0;
         post_cnt_d = '0;
         rd_left_d  = '0;
         trig_d     = 1'b0;
         rd_valid_d = 1'b0;
      end
   end

   // State and pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         entries_q  <= '0;
         post_cnt_q <= '0;
         rd_left_q  <= '0;
         trig_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         entries_q  <= entries_d;
         post_cnt_q <= post_cnt_d;
         rd_left_q  <= rd_left_d;
         trig_q     <= trig_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Read address runs one step ahead so a transfer is followed by the
   // next word without a bubble, and a stall re-reads the same slot.
   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (do_wr),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata),
      .raddr_i (rd_ptr_d),
      .rdata_o (rdata)
   );

   // RAM output is unreset, so data is forced to zero when not valid.
   assign rd_pc   = rd_valid_q ? rdata[EW-1 -: PC_W] : '0;
   assign rd_inst = rd_valid_q ? rdata[EW-PC_W-1 -: INST_W] : '0;
   assign rd_alu  = rd_valid_q ? rdata[EW-PC_W-INST_W-1 -: ALU_W] : '0;

   assign rd_valid  = rd_valid_q;
   assign state     = state_q;
   assign entries   = entries_q;
   assign triggered = trig_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb_debug_trace_buffer: directed capture scenarios with a readout scoreboard.
// DEPTH=8, POST_TRIG=3; timestamp gaps checked when TRACE_TSTAMP_EN is set.
module tb_debug_trace_buffer;
   import debug_trace_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] debug_pc;
   logic [31:0] debug_inst;
   logic [15:0] debug_alu_out;
   logic        arm;
   logic        abort;
   logic        trig_en;
   logic [31:0] trig_pc;
   logic        force_trig;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_pc;
   logic [31:0] rd_inst;
   logic [15:0] rd_alu;
`ifdef TRACE_TSTAMP_EN
   logic [15:0] rd_tstamp;
`endif
   logic [1:0]  state;
   logic [3:0]  entries;
   logic        triggered;

   int n_pass = 0;
   int n_tot  = 0;

   trace_entry_t exp_q[$];
   int           gap_q[$];

   always #5 clk = ~clk;

   debug_trace_buffer #(
      .DEPTH     (8),
      .POST_TRIG (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .debug_pc      (debug_pc),
      .debug_inst    (debug_inst),
      .debug_alu_out (debug_alu_out),
      .arm           (arm),
      .abort         (abort),
      .trig_en       (trig_en),
      .trig_pc       (trig_pc),
      .force_trig    (force_trig),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_pc         (rd_pc),
      .rd_inst       (rd_inst),
      .rd_alu        (rd_alu),
`ifdef TRACE_TSTAMP_EN
      .rd_tstamp     (rd_tstamp),
`endif
      .state         (state),
      .entries       (entries),
      .triggered     (triggered)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return 32'hC0DE_0000 ^ pc;
   endfunction

   function automatic logic [15:0] alu_of(input logic [31:0] pc);
      return 16'h5A00 ^ pc[15:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic v, input logic [31:0] pc,
                         input logic ft);
      in_valid      = v;
      debug_pc      = pc;
      debug_inst    = inst_of(pc);
      debug_alu_out = alu_of(pc);
      force_trig    = ft;
      tick();
      in_valid   = 1'b0;
      force_trig = 1'b0;
   endtask

   task automatic expect_word(input logic [31:0] pc, input int gap);
      trace_entry_t e;
      e = '0;
      e.pc   = pc;
      e.inst = inst_of(pc);
      e.alu  = alu_of(pc);
      exp_q.push_back(e);
      gap_q.push_back(gap);
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      n_tot++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL %s: %0d words never read, expected 0",
                    nm, exp_q.size());
      tick();
      tick();
   endtask

   // Scoreboard monitor: every accepted readout word is checked in order.
`ifdef TRACE_TSTAMP_EN
   logic [15:0] last_ts;
`endif
   always @(negedge clk) begin
      if (!reset && rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            n_tot++;
            $display("FAIL extra_word: got pc %0h expected none", rd_pc);
         end else begin
            trace_entry_t e;
            int g;
            e = exp_q.pop_front();
            g = gap_q.pop_front();
            chk("rd_pc", rd_pc, e.pc);
            chk("rd_inst", rd_inst, e.inst);
            chk("rd_alu", rd_alu, e.alu);
`ifdef TRACE_TSTAMP_EN
            if (g >= 0) chk("ts_gap", rd_tstamp - last_ts, g);
            last_ts = rd_tstamp;
`else
            if (g < -1) $display("bad gap entry %0d", g);
`endif
         end
      end
   end

   logic        vv [9];
   logic [31:0] vp [9];
   logic        vf [9];

   initial begin
      reset = 1'b1; in_valid = 0; debug_pc = 0; debug_inst = 0;
      debug_alu_out = 0; arm = 0; abort = 0; trig_en = 0; trig_pc = 0;
      force_trig = 0; rd_ready = 0;
      tick();
      tick();
      chk("rst_state", state, 0);
      chk("rst_entries", entries, 0);
      chk("rst_trig", triggered, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_pc", rd_pc, 0);
      reset = 1'b0;
      tick();

      // Wrapped window: trigger at 0x14, three post samples, ring full.
      trig_en = 1'b1;
      trig_pc = 32'h14;
      for (int i = 1; i <= 8; i++) expect_word(32'(i * 4), (i == 1) ? -1 : 1);
      do_arm();
      chk("arm_pre", state, 1);
      for (int i = 0; i < 10; i++) begin
         sample(1'b1, 32'(i * 4), 1'b0);
         if (i == 5) begin
            chk("s1_post", state, 2);
            chk("s1_trig", triggered, 1);
         end
         if (i == 8) begin
            chk("s1_done", state, 3);
            chk("s1_entries", entries, 8);
         end
      end
      chk("s1_valid_rise", rd_valid, 1);
      rd_ready = 1'b1;
      tick();
      tick();
      rd_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", rd_valid, 1);
         chk("stall_pc", rd_pc, exp_q[0].pc);
         chk("stall_inst", rd_inst, exp_q[0].inst);
         chk("stall_alu", rd_alu, exp_q[0].alu);
         tick();
      end
      rd_ready = 1'b1;
      drain("s1_drain");
      chk("s1_valid_end", rd_valid, 0);
      chk("s1_state_end", state, 3);
      chk("s1_entries_end", entries, 8);

      // Trigger on the first sample: short, unwrapped window.
      trig_pc = 32'h0;
      for (int i = 0; i < 4; i++) expect_word(32'(i * 4), (i == 0) ? -1 : 1);
      do_arm();
      chk("s2_pre", state, 1);
      chk("s2_entries0", entries, 0);
      chk("s2_trig0", triggered, 0);
      for (int i = 0; i < 10; i++) sample(1'b1, 32'(i * 4), 1'b0);
      drain("s2_drain");
      chk("s2_entries", entries, 4);
      chk("s2_valid_end", rd_valid, 0);

      // Gapped input with forced trigger: only valid samples count.
      trig_en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         vv[i] = (i % 2 == 0);
         vp[i] = 32'h100 + 32'(i * 4);
         vf[i] = (i == 2);
         if (i % 2 == 0) expect_word(vp[i], (i == 0) ? -1 : 2);
      end
      do_arm();
      for (int i = 0; i < 9; i++) begin
         sample(vv[i], vp[i], vf[i]);
         if (i == 7) chk("s3_still_post", state, 2);
      end
      chk("s3_done", state, 3);
      chk("s3_entries", entries, 5);
      drain("s3_drain");

      // Forced trigger without a sample, then abort during POST.
      do_arm();
      sample(1'b0, 32'h300, 1'b1);
      chk("s4_post", state, 2);
      chk("s4_entries0", entries, 0);
      chk("s4_trig", triggered, 1);
      sample(1'b1, 32'h304, 1'b0);
      chk("s4_entries1", entries, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_state", state, 0);
      chk("ab_entries", entries, 0);
      chk("ab_trig", triggered, 0);
      chk("ab_valid", rd_valid, 0);

      // Clean recapture after abort.
      trig_en = 1'b1;
      trig_pc = 32'h204;
      for (int i = 0; i < 5; i++)
         expect_word(32'h200 + 32'(i * 4), (i == 0) ? -1 : 1);
      do_arm();
      for (int i = 0; i < 6; i++) sample(1'b1, 32'h200 + 32'(i * 4), 1'b0);
      chk("s5_entries", entries, 5);
      drain("s5_drain");
      chk("s5_valid_end", rd_valid, 0);

      // Asynchronous reset mid-POST.
      rd_ready = 1'b0;
      trig_en  = 1'b0;
      do_arm();
      sample(1'b1, 32'h400, 1'b0);
      sample(1'b1, 32'h404, 1'b1);
      sample(1'b1, 32'h408, 1'b0);
      chk("s6_post", state, 2);
      chk("s6_entries", entries, 3);
      reset = 1'b1;
      #2;
      chk("rp_state", state, 0);
      chk("rp_entries", entries, 0);
      chk("rp_trig", triggered, 0);
      chk("rp_valid", rd_valid, 0);
      tick();
      reset = 1'b0;
      tick();

      // Asynchronous reset during a stalled readout.
      do_arm();
      sample(1'b1, 32'h500, 1'b1);
      for (int i = 1; i < 4; i++) sample(1'b1, 32'h500 + 32'(i * 4), 1'b0);
      tick();
      chk("s7_valid", rd_valid, 1);
      chk("s7_pc", rd_pc, 32'h500);
      reset = 1'b1;
      #2;
      chk("rr_valid", rd_valid, 0);
      chk("rr_pc", rd_pc, 0);
      chk("rr_inst", rd_inst, 0);
      chk("rr_alu", rd_alu, 0);
      chk("rr_state", state, 0);
      chk("rr_entries", entries, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

endmodule
